// File: rtl/board_double_buffer.sv
// ---------------------------------------------------------------------------
// board_double_buffer
//
// Two-bank board memory plus the generation sequencer that sits between the
// display path and life_logic. The front bank (index bank_sel) holds the
// current generation and serves both the life_logic read port and the display
// read port. The back bank (!bank_sel) collects life_logic writes for the next
// generation. The sequencer starts life_logic, waits for it to finish and for
// its trailing writes to drain, then swaps banks.
//
// Build option:
//   BUFFER_SWAP_ON_VSYNC_EN  defined   -> READY waits for frame_start_in
//                                         before swapping (tear-free, at most
//                                         one generation per frame); late_out
//                                         flags frames that arrive too early.
//                            undefined -> READY swaps on its first cycle
//                                         (compute-bound rate); late_out = 0.
//
// Ports:
//   clk_in            system clock, rising edge
//   rst_n_in          asynchronous active-low reset
//   frame_start_in    one-cycle pulse at start of vertical blanking
//   logic_start_out   registered one-cycle start pulse to life_logic
//   logic_done_in     done from life_logic
//   logic_addr_r_in   life_logic read address (front bank)
//   logic_data_r_out  front-bank read data, 1-cycle latency
//   logic_addr_w_in   life_logic write address (back bank)
//   logic_data_w_in   write data
//   logic_wr_en_in    back-bank write strobe
//   disp_addr_in      display read address (front bank)
//   disp_data_out     display read data, 1-cycle latency
//   bank_sel_out      index of the current front bank
//   gen_out           completed-swap count (wraps)
//   late_out          one-cycle pulse when a frame arrives before READY
// ---------------------------------------------------------------------------
module board_double_buffer #(
  parameter int WORD_SIZE    = 16,
  parameter int MAX_ADDR     = 4096,
  parameter int LOG_MAX_ADDR = 12,
  parameter int GEN_WIDTH    = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    frame_start_in,
  output logic                    logic_start_out,
  input  logic                    logic_done_in,
  input  logic [LOG_MAX_ADDR-1:0] logic_addr_r_in,
  output logic [WORD_SIZE-1:0]    logic_data_r_out,
  input  logic [LOG_MAX_ADDR-1:0] logic_addr_w_in,
  input  logic [WORD_SIZE-1:0]    logic_data_w_in,
  input  logic                    logic_wr_en_in,
  input  logic [LOG_MAX_ADDR-1:0] disp_addr_in,
  output logic [WORD_SIZE-1:0]    disp_data_out,
  output logic                    bank_sel_out,
  output logic [GEN_WIDTH-1:0]    gen_out,
  output logic                    late_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] READY = 2'd3;

  // One extra bit so that MAX_ADDR == 2**LOG_MAX_ADDR is representable.
  localparam logic [LOG_MAX_ADDR:0] ADDR_LIMIT = (LOG_MAX_ADDR+1)'(MAX_ADDR);

  logic [WORD_SIZE-1:0] r_bank0 [0:MAX_ADDR-1];
  logic [WORD_SIZE-1:0] r_bank1 [0:MAX_ADDR-1];

  logic [1:0]           r_state;
  logic [1:0]           r_blank;
  logic [1:0]           r_drain;
  logic                 r_start;
  logic                 r_bank_sel;
  logic [GEN_WIDTH-1:0] r_gen;
  logic [WORD_SIZE-1:0] r_logic_data;
  logic [WORD_SIZE-1:0] r_disp_data;

  logic w_logic_rd_ok;
  logic w_disp_rd_ok;
  logic w_wr_ok;
  logic w_swap;

  assign w_logic_rd_ok = ({1'b0, logic_addr_r_in} < ADDR_LIMIT);
  assign w_disp_rd_ok  = ({1'b0, disp_addr_in}    < ADDR_LIMIT);
  assign w_wr_ok       = ({1'b0, logic_addr_w_in} < ADDR_LIMIT);

`ifdef BUFFER_SWAP_ON_VSYNC_EN
  assign w_swap = (r_state == READY) && frame_start_in;
`else
  assign w_swap = (r_state == READY);
`endif

  // Generation sequencer. The blank counter keeps RUN deaf to logic_done_in
  // until it saturates, so a done left over from the previous generation
  // cannot end the new one early. DRAIN gives life_logic two more cycles for
  // writes that trail its done. The swap and the next start share one edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= IDLE;
      r_blank    <= 2'd0;
      r_drain    <= 2'd0;
      r_start    <= 1'b0;
      r_bank_sel <= 1'b0;
      r_gen      <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (frame_start_in) begin
            r_start <= 1'b1;
            r_blank <= 2'd0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (r_blank != 2'd3) begin
            r_blank <= r_blank + 2'd1;
          end else if (logic_done_in) begin
            r_drain <= 2'd2;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_drain <= 2'd1) begin
            r_drain <= 2'd0;
            r_state <= READY;
          end else begin
            r_drain <= r_drain - 2'd1;
          end
        end
        READY: begin
          if (w_swap) begin
            r_bank_sel <= ~r_bank_sel;
            r_gen      <= r_gen + GEN_WIDTH'(1);
            r_start    <= 1'b1;
            r_blank    <= 2'd0;
            r_state    <= RUN;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef BUFFER_SWAP_ON_VSYNC_EN
  logic r_late;

  // A frame that lands while the next generation is still being computed or
  // drained is reported and otherwise dropped.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_late <= 1'b0;
    end else begin
      r_late <= frame_start_in && ((r_state == RUN) || (r_state == DRAIN));
    end
  end

  assign late_out = r_late;
`else
  assign late_out = 1'b0;
`endif

  // Back-bank write port. Writes are accepted in every state so the
  // cursor/clear path can pre-load the back bank while the sequencer idles.
  // Bank contents are deliberately not reset.
  always_ff @(posedge clk_in) begin
    if (logic_wr_en_in && w_wr_ok) begin
      if (r_bank_sel) begin
        r_bank0[logic_addr_w_in] <= logic_data_w_in;
      end else begin
        r_bank1[logic_addr_w_in] <= logic_data_w_in;
      end
    end
  end

  // Front-bank read ports. They use the bank_sel value from before the edge,
  // so a read issued in the swap cycle still returns the old front bank.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_logic_data <= '0;
      r_disp_data  <= '0;
    end else begin
      if (!w_logic_rd_ok) begin
        r_logic_data <= '0;
      end else if (r_bank_sel) begin
        r_logic_data <= r_bank1[logic_addr_r_in];
      end else begin
        r_logic_data <= r_bank0[logic_addr_r_in];
      end
      if (!w_disp_rd_ok) begin
        r_disp_data <= '0;
      end else if (r_bank_sel) begin
        r_disp_data <= r_bank1[disp_addr_in];
      end else begin
        r_disp_data <= r_bank0[disp_addr_in];
      end
    end
  end

  assign logic_start_out  = r_start;
  assign logic_data_r_out = r_logic_data;
  assign disp_data_out    = r_disp_data;
  assign bank_sel_out     = r_bank_sel;
  assign gen_out          = r_gen;

endmodule

// File: tb/tb_board_double_buffer.sv
// ---------------------------------------------------------------------------
// tb_board_double_buffer
//
// Directed bench for board_double_buffer. Small memory (24 words, 5-bit
// address) so addresses 24..31 are out of range, and a 2-bit generation
// counter so wrap-around is reached quickly. Stimulus for swaps always pulses
// frame_start_in in the READY cycle, which makes the same expected timeline
// hold whether or not BUFFER_SWAP_ON_VSYNC_EN is defined.
// ---------------------------------------------------------------------------
module tb_board_double_buffer;

  localparam int WS = 16;
  localparam int MA = 24;
  localparam int LA = 5;
  localparam int GW = 2;

`ifdef BUFFER_SWAP_ON_VSYNC_EN
  localparam logic LATE_EXP = 1'b1;
`else
  localparam logic LATE_EXP = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          frame_start_in;
  logic          logic_start_out;
  logic          logic_done_in;
  logic [LA-1:0] logic_addr_r_in;
  logic [WS-1:0] logic_data_r_out;
  logic [LA-1:0] logic_addr_w_in;
  logic [WS-1:0] logic_data_w_in;
  logic          logic_wr_en_in;
  logic [LA-1:0] disp_addr_in;
  logic [WS-1:0] disp_data_out;
  logic          bank_sel_out;
  logic [GW-1:0] gen_out;
  logic          late_out;

  int testsRun    = 0;
  int testsFailed = 0;

  board_double_buffer #(
    .WORD_SIZE    (WS),
    .MAX_ADDR     (MA),
    .LOG_MAX_ADDR (LA),
    .GEN_WIDTH    (GW)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .frame_start_in   (frame_start_in),
    .logic_start_out  (logic_start_out),
    .logic_done_in    (logic_done_in),
    .logic_addr_r_in  (logic_addr_r_in),
    .logic_data_r_out (logic_data_r_out),
    .logic_addr_w_in  (logic_addr_w_in),
    .logic_data_w_in  (logic_data_w_in),
    .logic_wr_en_in   (logic_wr_en_in),
    .disp_addr_in     (disp_addr_in),
    .disp_data_out    (disp_data_out),
    .bank_sel_out     (bank_sel_out),
    .gen_out          (gen_out),
    .late_out         (late_out)
  );

  always #5 clk_in = ~clk_in;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to 1 ns after the next rising edge; outputs are sampled and
  // inputs changed there.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyReset();
    rst_n_in        = 1'b0;
    frame_start_in  = 1'b0;
    logic_done_in   = 1'b0;
    logic_wr_en_in  = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  // Pulse frame_start_in from IDLE; returns just after the start edge (P1).
  task automatic startGen();
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
  endtask

  task automatic test_reset();
    int starts;
    rst_n_in        = 1'b0;
    frame_start_in  = 1'b0;
    logic_done_in   = 1'b0;
    logic_wr_en_in  = 1'b0;
    logic_addr_r_in = '0;
    logic_addr_w_in = '0;
    logic_data_w_in = '0;
    disp_addr_in    = '0;
    #2;
    testsRun++;
    if ({logic_start_out, bank_sel_out, gen_out, late_out} !== 5'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: got start/sel/gen/late=%b expected 00000",
               {logic_start_out, bank_sel_out, gen_out, late_out});
    end
    testsRun++;
    if ({disp_data_out, logic_data_r_out} !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_data: got disp=%h logic=%h expected 0000/0000",
               disp_data_out, logic_data_r_out);
    end
    tick();
    tick();
    rst_n_in = 1'b1;
    starts = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (logic_start_out !== 1'b0) starts++;
    end
    testsRun++;
    if (starts != 0 || bank_sel_out !== 1'b0 || gen_out !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL idle_no_start: got starts=%0d sel=%b gen=%0d expected 0/0/0",
               starts, bank_sel_out, gen_out);
    end
  endtask

  task automatic test_preload_swap();
    logic_addr_w_in = 5'd5;
    logic_data_w_in = 16'hA5A5;
    logic_wr_en_in  = 1'b1;
    tick();
    logic_wr_en_in = 1'b0;
    startGen();
    testsRun++;
    if ({logic_start_out, bank_sel_out, gen_out} !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL first_start: got start/sel/gen=%b expected 1000",
               {logic_start_out, bank_sel_out, gen_out});
    end
    repeat (9) tick();
    logic_done_in = 1'b1;
    tick();
    logic_done_in = 1'b0;
    tick();
    tick();
    testsRun++;
    if ({logic_start_out, bank_sel_out, gen_out} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL pre_swap: got start/sel/gen=%b expected 0000",
               {logic_start_out, bank_sel_out, gen_out});
    end
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    testsRun++;
    if ({logic_start_out, bank_sel_out, gen_out} !== 4'b1101) begin
      testsFailed++;
      $display("[TB] FAIL swap1: got start/sel/gen=%b expected 1101",
               {logic_start_out, bank_sel_out, gen_out});
    end
    disp_addr_in    = 5'd5;
    logic_addr_w_in = 5'd3;
    logic_data_w_in = 16'h1234;
    logic_wr_en_in  = 1'b1;
    tick();
    logic_wr_en_in = 1'b0;
    testsRun++;
    if (disp_data_out !== 16'hA5A5) begin
      testsFailed++;
      $display("[TB] FAIL preload_read: got %h expected a5a5", disp_data_out);
    end
  endtask

  task automatic test_blank_drain();
    logic          expSel;
    logic [GW-1:0] expGen;
    applyReset();
    logic_done_in  = 1'b1;
    startGen();
    testsRun++;
    if (logic_start_out !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL blank_start: got %b expected 1", logic_start_out);
    end
    expSel = 1'b0;
    expGen = '0;
    for (int g = 1; g <= 4; g++) begin
      for (int c = 2; c <= 7; c++) begin
        tick();
        testsRun++;
        if ({logic_start_out, bank_sel_out} !== {1'b0, expSel}) begin
          testsFailed++;
          $display("[TB] FAIL blank_gen%0d_cyc%0d: got start/sel=%b expected %b",
                   g, c, {logic_start_out, bank_sel_out}, {1'b0, expSel});
        end
      end
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      expSel = ~expSel;
      expGen = expGen + GW'(1);
      testsRun++;
      if ({logic_start_out, bank_sel_out, gen_out} !== {1'b1, expSel, expGen}) begin
        testsFailed++;
        $display("[TB] FAIL swap_gen%0d: got start/sel/gen=%b expected %b",
                 g, {logic_start_out, bank_sel_out, gen_out}, {1'b1, expSel, expGen});
      end
    end
    logic_done_in = 1'b0;
  endtask

  task automatic test_drain_write();
    applyReset();
    startGen();
    repeat (3) tick();
    logic_done_in = 1'b1;
    tick();
    logic_done_in   = 1'b0;
    logic_addr_w_in = 5'd3;
    logic_data_w_in = 16'h0F0F;
    logic_wr_en_in  = 1'b1;
    tick();
    logic_wr_en_in = 1'b0;
    tick();
    frame_start_in  = 1'b1;
    logic_addr_r_in = 5'd3;
    disp_addr_in    = 5'd3;
    tick();
    frame_start_in = 1'b0;
    testsRun++;
    if (bank_sel_out !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL drain_swap: got sel=%b expected 1", bank_sel_out);
    end
    testsRun++;
    if ({logic_data_r_out, disp_data_out} !== {16'h1234, 16'h1234}) begin
      testsFailed++;
      $display("[TB] FAIL swap_cycle_read: got logic=%h disp=%h expected 1234/1234",
               logic_data_r_out, disp_data_out);
    end
    tick();
    testsRun++;
    if ({logic_data_r_out, disp_data_out} !== {16'h0F0F, 16'h0F0F}) begin
      testsFailed++;
      $display("[TB] FAIL drain_write_read: got logic=%h disp=%h expected 0f0f/0f0f",
               logic_data_r_out, disp_data_out);
    end
    disp_addr_in = 5'd30;
    tick();
    testsRun++;
    if (disp_data_out !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL out_of_range_read: got %h expected 0000", disp_data_out);
    end
  endtask

  task automatic test_late();
    applyReset();
    startGen();
    tick();
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    testsRun++;
    if ({late_out, logic_start_out, bank_sel_out, gen_out} !== {LATE_EXP, 4'b0000}) begin
      testsFailed++;
      $display("[TB] FAIL late_pulse: got late/start/sel/gen=%b expected %b",
               {late_out, logic_start_out, bank_sel_out, gen_out}, {LATE_EXP, 4'b0000});
    end
    tick();
    testsRun++;
    if ({late_out, bank_sel_out, gen_out} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL late_one_cycle: got late/sel/gen=%b expected 0000",
               {late_out, bank_sel_out, gen_out});
    end
  endtask

  task automatic test_async_reset();
    int starts;
    applyReset();
    startGen();
    repeat (3) tick();
    logic_done_in = 1'b1;
    tick();
    logic_done_in = 1'b0;
    tick();
    tick();
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    testsRun++;
    if ({bank_sel_out, gen_out} !== 3'b101) begin
      testsFailed++;
      $display("[TB] FAIL ar_swap: got sel/gen=%b expected 101", {bank_sel_out, gen_out});
    end
    logic_addr_r_in = 5'd3;
    disp_addr_in    = 5'd5;
    tick();
    testsRun++;
    if ({logic_data_r_out, disp_data_out} !== {16'h0F0F, 16'hA5A5}) begin
      testsFailed++;
      $display("[TB] FAIL ar_pre_read: got logic=%h disp=%h expected 0f0f/a5a5",
               logic_data_r_out, disp_data_out);
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    testsRun++;
    if ({logic_start_out, bank_sel_out, gen_out, late_out} !== 5'b0 ||
        {logic_data_r_out, disp_data_out} !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: got start/sel/gen/late=%b logic=%h disp=%h expected 00000/0000/0000",
               {logic_start_out, bank_sel_out, gen_out, late_out}, logic_data_r_out, disp_data_out);
    end
    tick();
    rst_n_in = 1'b1;
    starts = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (logic_start_out !== 1'b0) starts++;
    end
    testsRun++;
    if (starts != 0 || logic_data_r_out !== 16'h1234) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_idle: got starts=%0d logic=%h expected 0/1234",
               starts, logic_data_r_out);
    end
  endtask

  initial begin
    test_reset();
    test_preload_swap();
    test_blank_drain();
    test_drain_write();
    test_late();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
